// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI slave controller
//
// Purpose: holds the controller state encoding and the default frame width
// so the top level and any future siblings agree on them.
// Ports: none (package).

package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/CDCSynchron.sv
// rtl/CDCSynchron.sv - three-flop synchronizer with edge detection
//
// Purpose: brings one asynchronous level into the sysClk_i domain and
// reports its synchronized level plus single-cycle rising/falling pulses.
// Ports:
//   sysClk_i  system clock
//   reset_ni  asynchronous active-low reset (flops go to RESET_VAL)
//   async_i   asynchronous input level
//   sync_o    synchronized level (second flop)
//   rise_o    one-cycle pulse on a synchronized 0->1 transition
//   fall_o    one-cycle pulse on a synchronized 1->0 transition

module CDCSynchron #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sysClk_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // r_sync[0] is the metastability catcher, r_sync[1] the usable level,
  // r_sync[2] its one-cycle-old copy used for edge detection.
  logic [2:0] r_sync;

  always_ff @(posedge sysClk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync <= {3{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[1:0], async_i};
    end
  end

  assign sync_o = r_sync[1];
  assign rise_o = r_sync[1] & ~r_sync[2];
  assign fall_o = ~r_sync[1] & r_sync[2];

endmodule : CDCSynchron

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave with one-deep TX buffer
//
// Purpose: receives MSB-first frames on mosi_i sampled at SCK rising and
// transmits MSB-first on miso_o shifted at SCK falling. All SPI pins are
// oversampled by sysClk_i, which must be several times faster than SCK.
// Ports:
//   sysClk_i, reset_ni   system clock, async active-low reset
//   sck_i, cs_ni, mosi_i SPI inputs (asynchronous)
//   miso_o               SPI output, MSB of the shift-out register
//   rx_data_o/rx_valid_o last complete frame and its one-cycle strobe
//   tx_data_i/tx_load_i  TX buffer write, accepted only while tx_ready_o
//   tx_ready_o           TX buffer empty
//   busy_o               controller not in IDLE

module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '0
) (
  input  logic                  sysClk_i,
  input  logic                  reset_ni,
  input  logic                  sck_i,
  input  logic                  cs_ni,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_ready_o,
  output logic                  busy_o
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_sck_sync,  w_sck_rise,  w_sck_fall;
  logic w_cs_sync,   w_cs_rise,   w_cs_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  CDCSynchron #(.RESET_VAL(1'b0)) u_sync_sck (
    .sysClk_i (sysClk_i),
    .reset_ni (reset_ni),
    .async_i  (sck_i),
    .sync_o   (w_sck_sync),
    .rise_o   (w_sck_rise),
    .fall_o   (w_sck_fall)
  );

  CDCSynchron #(.RESET_VAL(1'b1)) u_sync_cs (
    .sysClk_i (sysClk_i),
    .reset_ni (reset_ni),
    .async_i  (cs_ni),
    .sync_o   (w_cs_sync),
    .rise_o   (w_cs_rise),
    .fall_o   (w_cs_fall)
  );

  CDCSynchron #(.RESET_VAL(1'b0)) u_sync_mosi (
    .sysClk_i (sysClk_i),
    .reset_ni (reset_ni),
    .async_i  (mosi_i),
    .sync_o   (w_mosi_sync),
    .rise_o   (w_mosi_rise),
    .fall_o   (w_mosi_fall)
  );

  // Only the MOSI level and the SCK edges matter to the datapath.
  assign w_unused_edges = ^{w_mosi_rise, w_mosi_fall, w_sck_sync};

  spi_state_e            r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic [DATA_WIDTH-1:0] r_shift_out;
  logic [DATA_WIDTH-1:0] r_tx_buf;
  logic                  r_tx_ready;
  logic                  r_skip_fall;
  logic [1:0]            r_warm;
  logic                  r_cs_armed;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_rx_next = {r_rx_shift, w_mosi_sync};

  // After reset the CS synchronizer holds its reset value (high) for two
  // cycles. If the pin is really low that would look like a falling edge,
  // so a falling edge is only honoured once CS has been seen genuinely high.
  always_ff @(posedge sysClk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_shift_out <= IDLE_FILL;
      r_tx_buf    <= '0;
      r_tx_ready  <= 1'b1;
      r_skip_fall <= 1'b0;
      r_warm      <= 2'd0;
      r_cs_armed  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end else if (w_cs_sync) begin
        r_cs_armed <= 1'b1;
      end

      // Writes are only taken into an empty buffer. A consume in the same
      // cycle sees the old (empty) state, ships IDLE_FILL and leaves the
      // new data buffered.
      if (tx_load_i && r_tx_ready) begin
        r_tx_buf   <= tx_data_i;
        r_tx_ready <= 1'b0;
      end

      if (w_cs_rise) begin
        r_state     <= IDLE;
        r_bit_cnt   <= '0;
        r_shift_out <= IDLE_FILL;
        r_skip_fall <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall && r_cs_armed) begin
              r_state <= LOAD;
            end
          end

          LOAD: begin
            r_shift_out <= r_tx_ready ? IDLE_FILL : r_tx_buf;
            if (!r_tx_ready) begin
              r_tx_ready <= 1'b1;
            end
            r_bit_cnt   <= '0;
            r_skip_fall <= 1'b0;
            r_state     <= SHIFT;
          end

          SHIFT: begin
            if (!w_cs_sync) begin
              if (w_sck_rise) begin
                r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
                if (r_bit_cnt == LAST_BIT) begin
                  r_bit_cnt   <= '0;
                  r_rx_data   <= w_rx_next;
                  r_rx_valid  <= 1'b1;
                  r_shift_out <= r_tx_ready ? IDLE_FILL : r_tx_buf;
                  if (!r_tx_ready) begin
                    r_tx_ready <= 1'b1;
                  end
                  // The falling edge that closes the last bit arrives after
                  // this reload; it must not shift out the new frame's MSB.
                  r_skip_fall <= 1'b1;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                end
              end else if (w_sck_fall) begin
                if (r_skip_fall) begin
                  r_skip_fall <= 1'b0;
                end else begin
                  r_shift_out <= {r_shift_out[DATA_WIDTH-2:0], 1'b0};
                end
              end
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign miso_o     = r_shift_out[DATA_WIDTH-1];
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign tx_ready_o = r_tx_ready;
  assign busy_o     = (r_state != IDLE);

endmodule : spi_slave_ctrl

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - scoreboard bench for spi_slave_ctrl

module tb_spi_slave_ctrl;

  localparam int H = 80;  // SCK half period, eight system clocks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] mi;
  int         n;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.DATA_WIDTH(8), .IDLE_FILL(8'h00)) dut (
    .sysClk_i   (clk),
    .reset_ni   (rst_n),
    .sck_i      (sck),
    .cs_ni      (cs_n),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .tx_data_i  (tx_data),
    .tx_load_i  (tx_load),
    .tx_ready_o (tx_ready),
    .busy_o     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic cs_high();
    #(H);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      #(H);
      sck = 1'b1;
      rd = {rd[6:0], miso};
      #(H);
      sck = 1'b0;
    end
    mosi = 1'b0;
  endtask

  // Monitor: every rx_valid pulse pops one expected frame.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (prev_valid) begin
        checks++;
        failures++;
        $display("FAIL rx_valid_width: got 2+ cycles expected 1");
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got rx_data %0h expected no pulse", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_q.pop_front());
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #35;
    chk("reset_miso", miso, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Buffered A5 goes out while 3C comes in.
    load(8'hA5);
    chk("a5_tx_ready_full", tx_ready, 0);
    exp_q.push_back(8'h3C);
    cs_low();
    chk("a5_busy", busy, 1);
    chk("a5_consumed", tx_ready, 1);
    xfer(8'h3C, 8, mi);
    chk("a5_miso", mi, 8'hA5);
    cs_high();
    chk("a5_idle", busy, 0);

    // Empty buffer sends the idle fill.
    exp_q.push_back(8'hFF);
    cs_low();
    xfer(8'hFF, 8, mi);
    chk("empty_miso", mi, 8'h00);
    cs_high();

    // Two frames under one CS, second byte loaded mid-frame.
    load(8'h11);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    cs_low();
    n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_wait", tx_ready, 1);
    load(8'h22);
    xfer(8'h81, 8, mi);
    chk("b2b_miso0", mi, 8'h11);
    xfer(8'h7E, 8, mi);
    chk("b2b_miso1", mi, 8'h22);
    cs_high();
    chk("b2b_ready_after", tx_ready, 1);

    // Aborted frame: no pulse, buffer written mid-frame survives.
    cs_low();
    load(8'h99);
    xfer(8'hFF, 5, mi);
    cs_high();
    chk("abort_busy", busy, 0);
    chk("abort_buf_kept", tx_ready, 0);
    exp_q.push_back(8'h5A);
    cs_low();
    xfer(8'h5A, 8, mi);
    chk("abort_next_miso", mi, 8'h99);
    cs_high();

    // A write into a full buffer is dropped.
    load(8'h77);
    load(8'hEE);
    chk("full_ready", tx_ready, 0);
    exp_q.push_back(8'h00);
    cs_low();
    xfer(8'h00, 8, mi);
    chk("full_miso", mi, 8'h77);
    cs_high();
    exp_q.push_back(8'h24);
    cs_low();
    xfer(8'h24, 8, mi);
    chk("full_no_ee", mi, 8'h00);
    cs_high();

    // Reset mid-frame, CS still low afterwards.
    cs_low();
    load(8'h42);
    xfer(8'hAA, 4, mi);
    #37;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_miso", miso, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(8'hFF, 8, mi);
    chk("rst_no_restart", busy, 0);
    cs_high();
    exp_q.push_back(8'hC3);
    cs_low();
    xfer(8'hC3, 8, mi);
    chk("rst_next_miso", mi, 8'h00);
    cs_high();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_slave_ctrl
